sccb_responder: RTL and testbench
=================================

# sccb_responder

SCCB target (camera-side) model that responds to the SCCB master bridge on SIOC/SIOD, decoding 3-phase write and 2-phase write + 2-phase read transactions into a simple register-access port. It oversamples the bus in the system clock domain, drives SIOD open-drain through an external IOBUF (I tied low), and is used both as a synthesizable loopback target for on-board bring-up and as the bench responder for the SCCB master path.

## Interface
- DEVICE_ID, 8'h42: 8-bit write ID; bit 0 ignored on compare, so 8'h43 addresses the read.
- SYNC_STAGES, 2: synchronizer depth on SIOC/SIOD; must be ≥2.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_sioc  in  1  SIOC pad input, asynchronous.
- i_siod  in  1  SIOD pad input (IOBUF O), asynchronous.
- o_siod_o  out  1  SIOD drive value (IOBUF I), constant 0.
- o_siod_t  out  1  SIOD tristate (IOBUF T); 1 = release, 0 = pull low.
- o_wr_en  out  1  one-cycle register write strobe.
- o_rd_en  out  1  one-cycle register read strobe.
- o_addr  out  8  register sub-address for o_wr_en/o_rd_en.
- o_wr_data  out  8  write data, valid with o_wr_en.
- i_rd_data  in  8  read data; must be valid the cycle after o_rd_en.
- o_busy  out  1  high between a detected START and the next STOP.

## Operation
- Reset values: o_siod_o=0, o_siod_t=1, o_wr_en=0, o_rd_en=0, o_addr=0, o_wr_data=0, o_busy=0; state IDLE; sub-address register 0.
- Synchronized SIOC/SIOD (SYNC_STAGES FFs, reset to 1) feed edge detect. Events, each a one-cycle pulse: SIOC rise, SIOC fall, START (SIOD 1→0 while SIOC high), STOP (SIOD 0→1 while SIOC high).
- Bits sampled MSB first on SIOC rise; SIOD drive changes only on SIOC fall.
- States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_NA, IGNORE.
- START from any state → ID, bit counter 0, o_siod_t=1, o_busy=1. STOP from any state → IDLE, o_siod_t=1, o_busy=0. START/STOP take priority over a coincident SIOC edge.
- ID: shift 8 bits. On 8th sample: ID[7:1]≠DEVICE_ID[7:1] → IGNORE (never drives). Match with R/W=0 → ID_ACK (write); R/W=1 → ID_ACK (read) and pulse o_rd_en with o_addr = sub-address register.
- *_ACK: on SIOC fall entering the 9th bit, o_siod_t=0; on following SIOC fall, o_siod_t=1 and go to next state (write ID → SUB; SUB_ACK → WDATA; WDATA_ACK → WDATA; read ID → RDATA).
- SUB: 8 bits into sub-address register; o_addr follows.
- WDATA: on 8th sample pulse o_wr_en with o_addr/o_wr_data; sub-address then increments mod 256 (0xFF→0x00) for further bytes.
- RDATA: latch i_rd_data into shifter the cycle after o_rd_en; on each SIOC fall drive o_siod_t = shifter MSB (1→release, 0→low) and shift. After 8 bits release for RDATA_NA; sample 9th bit, then IGNORE regardless of NA/ACK.
- 2-phase write (ID+SUB then STOP) only updates the sub-address; no o_wr_en.
- IGNORE: o_siod_t=1, waits for START/STOP.

## Timing
- Pad-to-event latency: SYNC_STAGES+1 i_clk cycles.
- Requirement: i_clk ≥ 8× SIOC frequency, and master SIOD setup/hold ≥ 4 i_clk periods.
- o_siod_t change: SYNC_STAGES+2 cycles after pad SIOC fall; must settle within SIOC low time.
- o_wr_en: SYNC_STAGES+2 cycles after pad SIOC rise of data bit 0.
- o_rd_en to shifter load: 1 cycle; first data bit driven on the ACK's closing SIOC fall.
- Reset mid-transaction: next cycle all outputs at reset values; SIOD released; resumes only at a new START.

## Structure
- Package sccb_pkg: state enum, SCCB_BITS=8, OV7670 ID constants (8'h42/8'h43), shared with the master-side bench.
- Sub-module sccb_line_sync: synchronizers, edge detect, START/STOP pulses.
- Top sccb_responder: FSM, bit counter, shifters, sub-address register.

## Test plan
- 3-phase write ID 0x42, sub 0x12, data 0x80 → one o_wr_en, o_addr=0x12, o_wr_data=0x80; SIOD pulled low in each 9th bit.
- 2-phase write 0x42/0x0A, STOP, 2-phase read 0x43 with i_rd_data=0x76 → o_rd_en with o_addr=0x0A; SIOD carries 0x76 MSB first; released in NA bit.
- ID 0x60 write → no strobes, o_siod_t stays 1 entire transaction, o_busy falls on STOP.
- Write 0x42, sub 0xFF, data 0x11, 0x22 → writes at 0xFF then 0x00.
- Repeated START after sub 0x30 then read 0x43 → o_rd_en at 0x30, correct data.
- i_rst asserted mid-RDATA while driving low → o_siod_t=1 next cycle, no further strobes until new START.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared SCCB constants: bit count, OV7670 device IDs and responder state codes.
package sccb_pkg;

  localparam int SCCB_BITS = 8;

  // OV7670 write ID; the read ID is the same address with the R/W bit set.
  localparam logic [7:0] OV7670_WR_ID = 8'h42;
  localparam logic [7:0] OV7670_RD_ID = 8'h43;

  // Responder FSM state codes, kept as plain constants so older tools and
  // checkers can compare against raw 4-bit values.
  typedef logic [3:0] sccb_state_t;

  localparam sccb_state_t ST_IDLE      = 4'd0;
  localparam sccb_state_t ST_ID        = 4'd1;
  localparam sccb_state_t ST_ID_ACK    = 4'd2;
  localparam sccb_state_t ST_SUB       = 4'd3;
  localparam sccb_state_t ST_SUB_ACK   = 4'd4;
  localparam sccb_state_t ST_WDATA     = 4'd5;
  localparam sccb_state_t ST_WDATA_ACK = 4'd6;
  localparam sccb_state_t ST_RDATA     = 4'd7;
  localparam sccb_state_t ST_RDATA_NA  = 4'd8;
  localparam sccb_state_t ST_IGNORE    = 4'd9;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes the asynchronous SIOC/SIOD pads into the system clock domain
// and turns them into one-cycle bus events: SIOC rise/fall, START and STOP.
// All events and the sampled SIOD level are registered together, so the
// consumer sees the SIOD value that belongs to each event in the same cycle.
// SYNC_STAGES must be at least 2.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sioc,
  input  logic i_siod,
  output logic o_sioc_rise,
  output logic o_sioc_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_siod_bit
);

  logic [SYNC_STAGES-1:0] sioc_sync;
  logic [SYNC_STAGES-1:0] siod_sync;
  logic                   sioc_prev;
  logic                   siod_prev;
  logic                   sioc_s;
  logic                   siod_s;

  assign sioc_s = sioc_sync[SYNC_STAGES-1];
  assign siod_s = siod_sync[SYNC_STAGES-1];

  // Synchronizer chains (idle bus level is high) and registered edge/condition detect.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sioc_sync   <= '1;
      siod_sync   <= '1;
      sioc_prev   <= 1'b1;
      siod_prev   <= 1'b1;
      o_sioc_rise <= 1'b0;
      o_sioc_fall <= 1'b0;
      o_start     <= 1'b0;
      o_stop      <= 1'b0;
      o_siod_bit  <= 1'b1;
    end else begin
      sioc_sync   <= {sioc_sync[SYNC_STAGES-2:0], i_sioc};
      siod_sync   <= {siod_sync[SYNC_STAGES-2:0], i_siod};
      sioc_prev   <= sioc_s;
      siod_prev   <= siod_s;
      o_sioc_rise <= sioc_s & ~sioc_prev;
      o_sioc_fall <= ~sioc_s & sioc_prev;
      // START/STOP only count while SIOC is stable high across the SIOD edge.
      o_start     <= sioc_s & sioc_prev & siod_prev & ~siod_s;
      o_stop      <= sioc_s & sioc_prev & ~siod_prev & siod_s;
      o_siod_bit  <= siod_s;
    end
  end

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes 3-phase writes and 2-phase write + 2-phase read
// transactions into a register-access port. SIOD is driven open-drain through
// an external IOBUF whose I input is tied low; o_siod_t = 0 pulls the line low.
//
// Register port: o_wr_en / o_rd_en are single-cycle strobes with no
// back-pressure. o_addr (and o_wr_data for writes) are valid in the strobe
// cycle; i_rd_data is sampled in the cycle after o_rd_en.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = OV7670_WR_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sioc,
  input  logic        i_siod,
  output logic        o_siod_o,
  output logic        o_siod_t,
  output logic        o_wr_en,
  output logic        o_rd_en,
  output logic [7:0]  o_addr,
  output logic [7:0]  o_wr_data,
  input  logic [7:0]  i_rd_data,
  output logic        o_busy,
  output sccb_state_t o_state
);

  localparam logic [3:0] LAST_BIT   = 4'(SCCB_BITS - 1);
  localparam logic [3:0] DRIVE_DONE = 4'(SCCB_BITS);

  logic        sioc_rise;
  logic        sioc_fall;
  logic        bus_start;
  logic        bus_stop;
  logic        siod_bit;

  sccb_state_t state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_in;
  logic [7:0]  rd_shift;
  logic [7:0]  sub_addr;
  logic        is_read;
  logic        ack_on;
  logic        rd_pend;
  logic [7:0]  in_byte;

  sccb_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sioc      (i_sioc),
    .i_siod      (i_siod),
    .o_sioc_rise (sioc_rise),
    .o_sioc_fall (sioc_fall),
    .o_start     (bus_start),
    .o_stop      (bus_stop),
    .o_siod_bit  (siod_bit)
  );

  // Byte as it stands once the current SIOC-rise bit is included.
  assign in_byte  = {shift_in[6:0], siod_bit};
  assign o_siod_o = 1'b0;
  assign o_state  = state;

  // Transaction FSM: bit counting, ACK driving, read shifting and register strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift_in  <= 8'h00;
      rd_shift  <= 8'hFF;
      sub_addr  <= 8'h00;
      is_read   <= 1'b0;
      ack_on    <= 1'b0;
      rd_pend   <= 1'b0;
      o_siod_t  <= 1'b1;
      o_wr_en   <= 1'b0;
      o_rd_en   <= 1'b0;
      o_addr    <= 8'h00;
      o_wr_data <= 8'h00;
      o_busy    <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      o_rd_en <= 1'b0;
      // Read data arrives one cycle after the read strobe.
      rd_pend <= o_rd_en;
      if (rd_pend) begin
        rd_shift <= i_rd_data;
      end

      if (bus_start) begin
        state    <= ST_ID;
        bit_cnt  <= 4'd0;
        is_read  <= 1'b0;
        ack_on   <= 1'b0;
        o_siod_t <= 1'b1;
        o_busy   <= 1'b1;
      end else if (bus_stop) begin
        state    <= ST_IDLE;
        ack_on   <= 1'b0;
        o_siod_t <= 1'b1;
        o_busy   <= 1'b0;
      end else begin
        case (state)
          ST_ID: begin
            if (sioc_rise) begin
              shift_in <= in_byte;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= 4'd0;
                if (in_byte[7:1] != DEVICE_ID[7:1]) begin
                  state <= ST_IGNORE;
                end else begin
                  state   <= ST_ID_ACK;
                  is_read <= in_byte[0];
                  if (in_byte[0]) begin
                    o_rd_en <= 1'b1;
                    o_addr  <= sub_addr;
                  end
                end
              end
            end
          end

          ST_SUB: begin
            if (sioc_rise) begin
              shift_in <= in_byte;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt  <= 4'd0;
                sub_addr <= in_byte;
                o_addr   <= in_byte;
                state    <= ST_SUB_ACK;
              end
            end
          end

          ST_WDATA: begin
            if (sioc_rise) begin
              shift_in <= in_byte;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt   <= 4'd0;
                o_wr_en   <= 1'b1;
                o_wr_data <= in_byte;
                o_addr    <= sub_addr;
                sub_addr  <= sub_addr + 8'd1;
                state     <= ST_WDATA_ACK;
              end
            end
          end

          // ACK bit: pull low on the fall that opens it, release (or start
          // driving read data) on the fall that closes it.
          ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
            if (sioc_fall) begin
              if (!ack_on) begin
                ack_on   <= 1'b1;
                o_siod_t <= 1'b0;
              end else begin
                ack_on   <= 1'b0;
                bit_cnt  <= 4'd0;
                o_siod_t <= 1'b1;
                if (state == ST_ID_ACK) begin
                  if (is_read) begin
                    state    <= ST_RDATA;
                    o_siod_t <= rd_shift[7];
                    rd_shift <= {rd_shift[6:0], 1'b1};
                    bit_cnt  <= 4'd1;
                  end else begin
                    state <= ST_SUB;
                  end
                end else begin
                  state <= ST_WDATA;
                end
              end
            end
          end

          ST_RDATA: begin
            if (sioc_fall) begin
              if (bit_cnt == DRIVE_DONE) begin
                o_siod_t <= 1'b1;
                state    <= ST_RDATA_NA;
              end else begin
                o_siod_t <= rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b1};
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end
          end

          // The master's NA/ACK level is not acted upon.
          ST_RDATA_NA: begin
            if (sioc_rise) begin
              state <= ST_IGNORE;
            end
          end

          default: begin
            o_siod_t <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: an SCCB master model drives the pads, a monitor
// checks every register strobe against an expected queue, and bus-level
// results (ACK levels, read data, busy, release) are checked inline.
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam int Q = 8;  // quarter SIOC period in i_clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        sioc_pad;
  logic        m_sda;
  logic        siod_pad;
  logic        o_siod_o;
  logic        o_siod_t;
  logic        o_wr_en;
  logic        o_rd_en;
  logic [7:0]  o_addr;
  logic [7:0]  o_wr_data;
  logic [7:0]  i_rd_data;
  logic        o_busy;
  sccb_state_t o_state;

  int checks = 0;
  int errors = 0;
  logic        driven_seen = 1'b0;
  logic [16:0] exp_q[$];  // {is_write, addr, data (0 for reads)}

  // Open-drain wired-AND of master and responder with pull-up.
  assign siod_pad = m_sda & (o_siod_t | o_siod_o);

  sccb_responder dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sioc    (sioc_pad),
    .i_siod    (siod_pad),
    .o_siod_o  (o_siod_o),
    .o_siod_t  (o_siod_t),
    .o_wr_en   (o_wr_en),
    .o_rd_en   (o_rd_en),
    .o_addr    (o_addr),
    .o_wr_data (o_wr_data),
    .i_rd_data (i_rd_data),
    .o_busy    (o_busy),
    .o_state   (o_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [16:0] got;
    logic [16:0] exp;
    if (o_wr_en === 1'b1 || o_rd_en === 1'b1) begin
      got = {o_wr_en, o_addr, (o_wr_en ? o_wr_data : 8'h00)};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got=%h required=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL strobe got=%h required=%h", got, exp);
        end
      end
    end
    if (o_siod_t === 1'b0) driven_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  // Master driver tasks.
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    sioc_pad = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    sioc_pad = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    sioc_pad = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wait_q();
      sioc_pad = 1'b1; wait_q();
      wait_q();
      sioc_pad = 1'b0; wait_q();
    end
    m_sda = 1'b1; wait_q();
    sioc_pad = 1'b1; wait_q();
    ack = siod_pad; wait_q();
    sioc_pad = 1'b0; wait_q();
  endtask

  task automatic read_byte(output logic [7:0] d, output logic na);
    for (int i = 7; i >= 0; i--) begin
      m_sda = 1'b1; wait_q();
      sioc_pad = 1'b1; wait_q();
      d[i] = siod_pad; wait_q();
      sioc_pad = 1'b0; wait_q();
    end
    m_sda = 1'b1; wait_q();
    sioc_pad = 1'b1; wait_q();
    na = siod_pad; wait_q();
    sioc_pad = 1'b0; wait_q();
  endtask

  // Directed scenarios.
  initial begin
    logic       ack;
    logic       na;
    logic [7:0] rd;

    rst = 1'b1; sioc_pad = 1'b1; m_sda = 1'b1; i_rd_data = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_siod_t", o_siod_t, 1);
    check("rst_siod_o", o_siod_o, 0);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_rd_en", o_rd_en, 0);
    check("rst_addr", o_addr, 0);
    check("rst_wr_data", o_wr_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_state", o_state, ST_IDLE);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 3-phase write 0x42 / 0x12 / 0x80.
    bus_start();
    check("busy_after_start", o_busy, 1);
    write_byte(OV7670_WR_ID, ack); check("w1_id_ack", ack, 0);
    write_byte(8'h12, ack);        check("w1_sub_ack", ack, 0);
    exp_q.push_back({1'b1, 8'h12, 8'h80});
    write_byte(8'h80, ack);        check("w1_data_ack", ack, 0);
    check("w1_released", o_siod_t, 1);
    bus_stop();
    check("busy_after_stop", o_busy, 0);

    // 2-phase write of sub 0x0A, then 2-phase read returning 0x76.
    bus_start();
    write_byte(OV7670_WR_ID, ack); check("w2_id_ack", ack, 0);
    write_byte(8'h0A, ack);        check("w2_sub_ack", ack, 0);
    bus_stop();
    i_rd_data = 8'h76;
    bus_start();
    exp_q.push_back({1'b0, 8'h0A, 8'h00});
    write_byte(OV7670_RD_ID, ack); check("r1_id_ack", ack, 0);
    read_byte(rd, na);
    check("r1_data", rd, 8'h76);
    check("r1_na_released", na, 1);
    bus_stop();

    // Foreign ID 0x60: never driven, no strobes, busy until STOP.
    driven_seen = 1'b0;
    bus_start();
    write_byte(8'h60, ack); check("ign_id_ack", ack, 1);
    write_byte(8'h12, ack); check("ign_sub_ack", ack, 1);
    write_byte(8'h55, ack); check("ign_data_ack", ack, 1);
    check("ign_busy", o_busy, 1);
    bus_stop();
    check("ign_busy_after_stop", o_busy, 0);
    check("ign_never_driven", driven_seen, 0);

    // Auto-increment wrap 0xFF -> 0x00.
    bus_start();
    write_byte(OV7670_WR_ID, ack); check("w3_id_ack", ack, 0);
    write_byte(8'hFF, ack);        check("w3_sub_ack", ack, 0);
    exp_q.push_back({1'b1, 8'hFF, 8'h11});
    write_byte(8'h11, ack);        check("w3_d0_ack", ack, 0);
    exp_q.push_back({1'b1, 8'h00, 8'h22});
    write_byte(8'h22, ack);        check("w3_d1_ack", ack, 0);
    bus_stop();

    // Repeated START after sub 0x30, then read.
    i_rd_data = 8'hA5;
    bus_start();
    write_byte(OV7670_WR_ID, ack); check("r2_wid_ack", ack, 0);
    write_byte(8'h30, ack);        check("r2_sub_ack", ack, 0);
    bus_start();
    exp_q.push_back({1'b0, 8'h30, 8'h00});
    write_byte(OV7670_RD_ID, ack); check("r2_rid_ack", ack, 0);
    read_byte(rd, na);
    check("r2_data", rd, 8'hA5);
    check("r2_na_released", na, 1);
    bus_stop();

    // Reset while driving a 0 read bit.
    i_rd_data = 8'h3C;
    bus_start();
    write_byte(OV7670_WR_ID, ack); check("r3_wid_ack", ack, 0);
    write_byte(8'h05, ack);        check("r3_sub_ack", ack, 0);
    bus_start();
    exp_q.push_back({1'b0, 8'h05, 8'h00});
    write_byte(OV7670_RD_ID, ack); check("r3_rid_ack", ack, 0);
    check("r3_driving_low", o_siod_t, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("r3_rst_siod_t", o_siod_t, 1);
    check("r3_rst_busy", o_busy, 0);
    check("r3_rst_addr", o_addr, 0);
    check("r3_rst_state", o_state, ST_IDLE);
    driven_seen = 1'b0;
    read_byte(rd, na);
    check("r3_after_rst_released", rd, 8'hFF);
    check("r3_after_rst_not_driven", driven_seen, 0);
    bus_stop();

    // New transaction after reset: sub-address is back at 0.
    i_rd_data = 8'hC3;
    bus_start();
    exp_q.push_back({1'b0, 8'h00, 8'h00});
    write_byte(OV7670_RD_ID, ack); check("r4_id_ack", ack, 0);
    read_byte(rd, na);
    check("r4_data", rd, 8'hC3);
    bus_stop();

    repeat (20) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
